// File: rtl/multicycle_ctrl.sv
// Control FSM for the 8-bit multicycle MIPS datapath: fetch, decode, execute, memory, writeback.
// Outputs are registered from the next state; only the branch-taken pcen term looks at zero directly.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3 = 4'd2,  FETCH4 = 4'd3,
        DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD   = 4'd6,  LBWR   = 4'd7,
        SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX = 4'd11,
        JEX     = 4'd12, ADDIEX  = 4'd13, ADDIWR = 4'd14, UNUSED = 4'd15
    } state_t;

    localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_RTYPE = 6'b000000,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic [3:0] irwrite;
        logic       pcen;
        logic       beq;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic [2:0] alucontrol;
    } ctl_t;

    function automatic ctl_t decode(input state_t s, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
                c.alusrcb = 2'b01;
                c.pcen    = 1'b1;
            end
            DECODE:         c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                case (fn)
                    6'b100010: c.alucontrol = 3'b110;
                    6'b100100: c.alucontrol = 3'b000;
                    6'b100101: c.alucontrol = 3'b001;
                    6'b101010: c.alucontrol = 3'b111;
                    default:   c.alucontrol = 3'b010;
                endcase
            end
            RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            ADDIWR:  c.regwrite = 1'b1;
            BEQEX: begin
                c.alusrca    = 1'b1;
                c.alucontrol = 3'b110;
                c.pcsrc      = 2'b01;
                c.beq        = 1'b1;
            end
            JEX: begin
                c.pcsrc = 2'b10;
                c.pcen  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    localparam ctl_t CTL_RST = decode(FETCH1, 6'b000000);

    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;

    always_comb begin
        w_next = FETCH1;
        case (r_state)
            FETCH1:  w_next = FETCH2;
            FETCH2:  w_next = FETCH3;
            FETCH3:  w_next = FETCH4;
            FETCH4:  w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_J:         w_next = JEX;
                    OP_ADDI:      w_next = ADDIEX;
                    default:      w_next = FETCH1;
                endcase
            end
            // op is still held in the IR here, so it picks load vs store
            MEMADR:  w_next = (op == OP_SB) ? SBWR : LBRD;
            LBRD:    w_next = LBWR;
            RTYPEEX: w_next = RTYPEWR;
            ADDIEX:  w_next = ADDIWR;
            default: w_next = FETCH1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH1;
            r_ctl   <= CTL_RST;
        end else begin
            r_state <= w_next;
            r_ctl   <= decode(w_next, funct);
        end
    end

    assign memread    = r_ctl.memread;
    assign memwrite   = r_ctl.memwrite;
    assign alusrca    = r_ctl.alusrca;
    assign alusrcb    = r_ctl.alusrcb;
    assign iord       = r_ctl.iord;
    assign irwrite    = r_ctl.irwrite;
    assign pcen       = r_ctl.pcen | (r_ctl.beq & zero);
    assign pcsrc      = r_ctl.pcsrc;
    assign regwrite   = r_ctl.regwrite;
    assign regdst     = r_ctl.regdst;
    assign memtoreg   = r_ctl.memtoreg;
    assign alucontrol = r_ctl.alucontrol;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected state/outputs are queued per instruction and
// compared on the falling edge as the FSM walks through them.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, pcen, regwrite, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] irwrite, state;
    logic [2:0] alucontrol;

    int n_checks = 0;
    int n_errors = 0;
    logic [22:0] sb_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .iord(iord), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    // {state, memread, memwrite, alusrca, alusrcb, iord, irwrite, pcen, pcsrc, regwrite, regdst, memtoreg, alucontrol}
    function automatic logic [22:0] exp_vec(input int st, input logic [5:0] fn, input logic z);
        logic mr = 0, mw = 0, asa = 0, io = 0, pe = 0, rw = 0, rd = 0, m2r = 0;
        logic [1:0] asb = 2'b00, ps = 2'b00;
        logic [3:0] irw = 4'b0000;
        logic [2:0] alu = 3'b010;
        case (st)
            0, 1, 2, 3: begin mr = 1; irw = 4'b0001 << st; asb = 2'b01; pe = 1; end
            4:          asb = 2'b11;
            5, 13:      begin asa = 1; asb = 2'b10; end
            6:          begin mr = 1; io = 1; end
            7:          begin rw = 1; m2r = 1; end
            8:          begin mw = 1; io = 1; end
            9: begin
                asa = 1;
                case (fn)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
            end
            10:         begin rw = 1; rd = 1; end
            11:         begin asa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
            12:         begin ps = 2'b10; pe = 1; end
            14:         rw = 1;
            default: ;
        endcase
        return {4'(st), mr, mw, asa, asb, io, irw, pe, ps, rw, rd, m2r, alu};
    endfunction

    function automatic logic [22:0] act_vec();
        return {state, memread, memwrite, alusrca, alusrcb, iord, irwrite, pcen, pcsrc,
                regwrite, regdst, memtoreg, alucontrol};
    endfunction

    // Queue the expected cycle-by-cycle trace of one instruction (first n states only if n > 0).
    task automatic push_instr(input logic [5:0] o, input logic [5:0] fn, input logic z, input int n);
        int s[$];
        s = '{0, 1, 2, 3, 4};
        case (o)
            6'b100000: s = {s, 5, 6, 7};
            6'b101000: s = {s, 5, 8};
            6'b000000: s = {s, 9, 10};
            6'b000100: s = {s, 11};
            6'b000010: s = {s, 12};
            6'b001000: s = {s, 13, 14};
            default: ;
        endcase
        if (n > 0) s = s[0:n-1];
        op = o; funct = fn; zero = z;
        foreach (s[i]) sb_q.push_back(exp_vec(s[i], fn, z));
    endtask

    task automatic drain(input string name);
        logic [22:0] e, a;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s st%0d: got %b want %b", name, e[22:19], a, e);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1; op = 6'b111111; funct = 6'b0; zero = 0;
        #2;
        n_checks++;
        if (act_vec() !== exp_vec(0, 6'b0, 0)) begin
            n_errors++;
            $display("FAIL reset_hold: got %b want %b", act_vec(), exp_vec(0, 6'b0, 0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_lb();
        push_instr(6'b100000, 6'b0, 0, 0); drain("lb");
    endtask

    task automatic test_rtype();
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        foreach (fns[i]) begin
            push_instr(6'b000000, fns[i], 0, 0);
            drain("rtype");
        end
    endtask

    task automatic test_beq();
        push_instr(6'b000100, 6'b0, 1, 0); drain("beq_taken");
        push_instr(6'b000100, 6'b0, 0, 0); drain("beq_not_taken");
        // Mealy term: pcen follows zero within BEQEX without a clock edge
        push_instr(6'b000100, 6'b0, 0, 5); drain("beq_mealy_pre");
        zero = 1; #1;
        n_checks++;
        if (pcen !== 1'b1 || state !== 4'd11) begin
            n_errors++;
            $display("FAIL beq_mealy: got pcen=%b state=%0d want pcen=1 state=11", pcen, state);
        end
        zero = 0; #1;
        n_checks++;
        if (pcen !== 1'b0) begin
            n_errors++;
            $display("FAIL beq_mealy_low: got pcen=%b want 0", pcen);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_sb_j_addi();
        push_instr(6'b101000, 6'b0, 0, 0); drain("sb");
        push_instr(6'b000010, 6'b0, 0, 0); drain("j");
        push_instr(6'b001000, 6'b0, 0, 0); drain("addi");
    endtask

    task automatic test_illegal();
        push_instr(6'b111111, 6'b0, 1, 0); drain("illegal");
        push_instr(6'b111111, 6'b0, 1, 0); drain("illegal_again");
    endtask

    task automatic test_reset_mid();
        push_instr(6'b100000, 6'b0, 0, 6); drain("lb_to_lbrd");
        // now mid-LBRD; reset must take effect without a clock edge
        #2 reset = 1;
        #1;
        n_checks++;
        if (act_vec() !== exp_vec(0, 6'b0, 0)) begin
            n_errors++;
            $display("FAIL reset_async: got %b want %b", act_vec(), exp_vec(0, 6'b0, 0));
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || regwrite !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held: got state=%0d regwrite=%b want 0 0", state, regwrite);
        end
        reset = 0;
        push_instr(6'b100000, 6'b0, 0, 0); drain("lb_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b010101};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        for (int k = 0; k < 20; k++) begin
            push_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 0);
            drain("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_rtype();
        test_beq();
        test_sb_j_addi();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (state !== 4'd0) begin
            n_errors++;
            $display("FAIL final_state: got %0d want 0", state);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
